serial_adder_ctrl: RTL
======================

# serial_adder_ctrl

Bit-serial adder controller that time-multiplexes one `full_adder` instance to add two WIDTH-bit operands, one bit per clock, LSB first. It latches operands on a start request, sequences the single full-adder datapath WIDTH times with a registered carry, and presents a held result with a one-cycle `done` pulse. It sits between a requester and the shared `full_adder`/`half_adder` datapath. It trades latency for a one-adder footprint.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width in bits; must be ≥ 2.

Ports:
- `clk`  input  1  rising-edge clock; the block's only clock.
- `reset`  input  1  synchronous, active-high reset, sampled on `clk` rising edge.
- `start`  input  1  operation request; accepted only in IDLE.
- `a`  input  WIDTH  operand A; sampled at the accepting edge only.
- `b`  input  WIDTH  operand B; sampled at the accepting edge only.
- `cin`  input  1  carry-in; sampled at the accepting edge only.
- `busy`  output  1  high while bits are being processed (state ADD).
- `done`  output  1  one-cycle pulse; result valid and updated.
- `sum`  output  WIDTH  last completed sum; held until the next completion.
- `carry_out`  output  1  last completed carry out; held with `sum`.

## Operation
- Exactly one `full_adder` instance. Its inputs are `a_sh[0]`, `b_sh[0]` and the `carry_reg`. Its outputs are the sum bit and the next carry. No other adder logic is allowed.
- Internal registers:
  - `a_sh`, `b_sh`: WIDTH-bit operand shift registers.
  - `s_sh`: WIDTH-bit result shift register.
  - `carry_reg`: 1 bit.
  - `cnt`: bit counter, width clog2(WIDTH).
- States:
  - IDLE: waiting. `start`=1 → load `a_sh`←`a`, `b_sh`←`b`, `carry_reg`←`cin`, `cnt`←0, go to ADD. `start`=0 → stay in IDLE.
  - ADD: on each edge:
    - `s_sh`←{fa_sum, `s_sh[WIDTH-1:1]`}
    - `a_sh`, `b_sh` shift right by 1, zero-filled
    - `carry_reg`←fa_carry
    - `cnt`←`cnt`+1
    - When `cnt`==WIDTH-1 at the edge: `sum`←{fa_sum, `s_sh[WIDTH-1:1]`}, `carry_out`←fa_carry, go to DONE.
  - DONE: `done`=1 for this cycle only. The next edge goes unconditionally to IDLE.
- `start` in ADD or DONE is ignored and not queued. Operand changes after acceptance have no effect.
- Arithmetic: {`carry_out`,`sum`} = `a`+`b`+`cin`, computed modulo 2^(WIDTH+1). No overflow flag.
- Reset (any state, including mid-ADD):
  - state→IDLE; all internal registers→0.
  - `busy`=0, `done`=0, `sum`=0, `carry_out`=0.
  - The in-flight operation is discarded; no `done` is produced for it.
- Reset and `start` asserted on the same edge: reset wins, and the block stays in IDLE.

## Timing
- Outputs are registered or decoded purely from state. There is no combinational path from inputs to outputs.
- Accepting edge E0 (IDLE, `start`=1). `busy`=1 from after E0 through after E(WIDTH-1). The WIDTH bit edges are E1..E(WIDTH).
- After E(WIDTH): `busy`=0, `done`=1, `sum` and `carry_out` updated. After E(WIDTH+1): IDLE, `done`=0.
- Latency: `done` is high in the cycle following E(WIDTH), i.e. WIDTH cycles after the accepting edge.
- Throughput: one operation per WIDTH+2 cycles. The earliest next accept is E(WIDTH+2), with `start` held high.
- `sum` and `carry_out` never show partial results; they change only at the edge entering DONE or at reset.

## Test plan
- WIDTH=8: `a`=8'h3C, `b`=8'h42, `cin`=0, `start` pulsed one cycle → `done` 8 cycles after the accepting edge; `sum`=8'h7E, `carry_out`=0.
- Carry ripple through all bits: 8'hFF + 8'h01, `cin`=0 → `sum`=8'h00, `carry_out`=1. Then 8'hFF + 8'hFF, `cin`=1 → `sum`=8'hFF, `carry_out`=1.
- Busy behaviour with `start`=1 held continuously and operands changed mid-ADD:
  - `start` is ignored while `busy`/`done`.
  - First result uses the operands from the accepting edge.
  - Second operation is accepted exactly WIDTH+2 cycles after the first accept.
- Reset asserted for one cycle midway through ADD (after 4 bits):
  - Next cycle: `busy`=0, `done`=0, `sum`=0, `carry_out`=0.
  - No `done` pulse follows.
  - A fresh `start` then completes correctly.
- Random sweep, 500 operand/`cin` triples, WIDTH=8 and WIDTH=5:
  - {`carry_out`,`sum`} matches the reference sum every time.
  - `done` is exactly one cycle wide.
  - `sum` is stable between `done` pulses.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
//==============================================================================
// Module   : serial_adder_ctrl (with half_adder / full_adder datapath cells)
// Brief    : Bit-serial adder, one full_adder reused WIDTH times, LSB first.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module half_adder (
    input  logic i_a,
    input  logic i_b,
    output logic o_sum,
    output logic o_carry
);
    assign o_sum   = i_a ^ i_b;
    assign o_carry = i_a & i_b;
endmodule

module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_carry
);
    logic w_s1, w_c1, w_c2;

    half_adder u_ha0 (.i_a(i_a),  .i_b(i_b),   .o_sum(w_s1),  .o_carry(w_c1));
    half_adder u_ha1 (.i_a(w_s1), .i_b(i_cin), .o_sum(o_sum), .o_carry(w_c2));

    assign o_carry = w_c1 | w_c2;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    // Bit 0 of the result shifter would be shifted out unread, so it is not kept.
    logic [WIDTH-1:1] r_s_sh;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_co;
    logic             w_fa_sum;
    logic             w_fa_carry;
    logic             w_last;
    logic [WIDTH-1:0] w_s_next;

    full_adder u_fa (
        .i_a    (r_a_sh[0]),
        .i_b    (r_b_sh[0]),
        .i_cin  (r_carry),
        .o_sum  (w_fa_sum),
        .o_carry(w_fa_carry)
    );

    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_s_next = {w_fa_sum, r_s_sh[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_ADD;
            S_ADD:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_s_sh  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_co    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                    end
                end
                S_ADD: begin
                    r_s_sh  <= w_s_next[WIDTH-1:1];
                    r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_carry <= w_fa_carry;
                    r_cnt   <= r_cnt + 1'b1;
                    // Published only on the final bit so sum never shows partials.
                    if (w_last) begin
                        r_sum <= w_s_next;
                        r_co  <= w_fa_carry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state == S_ADD);
    assign done      = (r_state == S_DONE);
    assign sum       = r_sum;
    assign carry_out = r_co;

endmodule

`default_nettype wire
